// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions used by the write-back arbiter and its FIFO.
package cpu_pkg;

    localparam int REG_AW   = 5;
    localparam int XLEN     = 32;
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    // Source driving the register-file write port in a given cycle.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ALU  = 2'd1,
        S_LD   = 2'd2,
        S_FULL = 2'd3
    } wb_sel_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of the ALU result, load response and register-file write signals
// around the write-back arbiter. The arbiter is the slave side.
interface wb_arbiter_if
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = XLEN,
    parameter int AW    = REG_AW
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;

    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_rd;
    logic [DW-1:0] ld_data;

    logic [AW-1:0] RD;
    logic [DW-1:0] WData;
    logic          RegWr;

    logic [31:0]   pend_mask;
    logic [CW-1:0] fifo_count;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        input  alu_ready, ld_ready,
        input  RD, WData, RegWr, pend_mask, fifo_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        output alu_ready, ld_ready,
        output RD, WData, RegWr, pend_mask, fifo_count
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO for buffered load responses. Besides the head entry it
// exposes per-slot valid bits and stored destinations so the owner can see
// which registers still have a load in flight.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      push_i,
    input  logic [AW-1:0]             push_rd_i,
    input  logic [DW-1:0]             push_data_i,
    input  logic                      pop_i,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [AW-1:0]             head_rd_o,
    output logic [DW-1:0]             head_data_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic [DEPTH-1:0]          valid_o,
    output logic [DEPTH-1:0][AW-1:0]  rd_vec_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic             push_ok, pop_ok;

    logic [AW-1:0]    rd_mem_q   [DEPTH];
    logic [DW-1:0]    data_mem_q [DEPTH];

    assign full_o      = (count_q == CNT_FULL);
    assign empty_o     = (count_q == '0);
    assign push_ok     = push_i && !full_o;
    assign pop_ok      = pop_i && !empty_o;
    assign head_rd_o   = rd_mem_q[rd_ptr_q];
    assign head_data_o = data_mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign valid_o     = valid_q;

    // Expose stored destinations; stale slots are masked by valid_o.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rd_vec_o[i] = rd_mem_q[i];
        end
    end

    // Next pointers, occupancy and slot-valid bits. Pointers wrap naturally
    // because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (push_ok) begin
            wr_ptr_d          = wr_ptr_q + PTR_ONE;
            valid_d[wr_ptr_q] = 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d          = rd_ptr_q + PTR_ONE;
            valid_d[rd_ptr_q] = 1'b0;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control state; reset discards everything buffered.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Entry storage; contents only matter while the slot is valid.
    always_ff @(posedge Clk) begin
        if (push_ok) begin
            rd_mem_q[wr_ptr_q]   <= push_rd_i;
            data_mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter in front of the register file. ALU results win the
// single write port unless the load FIFO is full, in which case the oldest
// load is drained so buffered loads cannot starve.
module wb_arbiter
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = XLEN,
    parameter int AW    = REG_AW
) (
    input  logic        Clk,
    input  logic        Reset,
    wb_arbiter_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                     fifo_full, fifo_empty;
    logic [AW-1:0]            head_rd;
    logic [DW-1:0]            head_data;
    logic [CW-1:0]            fifo_cnt;
    logic [DEPTH-1:0]         ent_valid;
    logic [DEPTH-1:0][AW-1:0] ent_rd;
    logic                     push, pop;
    wb_sel_t                  sel;

    logic [AW-1:0] rd_q, rd_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          regwr_q, regwr_d;
    logic [31:0]   pend_mask_c;

    wb_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_fifo (
        .Clk         (Clk),
        .Reset       (Reset),
        .push_i      (push),
        .push_rd_i   (bus.ld_rd),
        .push_data_i (bus.ld_data),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_rd_o   (head_rd),
        .head_data_o (head_data),
        .count_o     (fifo_cnt),
        .valid_o     (ent_valid),
        .rd_vec_o    (ent_rd)
    );

    // No pass-through when full: a full FIFO refuses the new load outright.
    assign push          = bus.ld_valid && !fifo_full;
    assign bus.ld_ready  = !fifo_full;
    assign bus.alu_ready = (sel != S_FULL);
    assign bus.fifo_count = fifo_cnt;

    // Priority select: full FIFO, then ALU, then pending load, else idle.
    always_comb begin
        sel = S_IDLE;
        if (fifo_full) begin
            sel = S_FULL;
        end else if (bus.alu_valid) begin
            sel = S_ALU;
        end else if (!fifo_empty) begin
            sel = S_LD;
        end
    end

    // Next write-port value; x0 targets are consumed but never written.
    always_comb begin
        rd_d    = rd_q;
        wdata_d = wdata_q;
        regwr_d = 1'b0;
        pop     = 1'b0;
        case (sel)
            S_FULL, S_LD: begin
                pop     = 1'b1;
                rd_d    = head_rd;
                wdata_d = head_data;
                regwr_d = (head_rd != AW'(REG_ZERO));
            end
            S_ALU: begin
                rd_d    = bus.alu_rd;
                wdata_d = bus.alu_data;
                regwr_d = (bus.alu_rd != AW'(REG_ZERO));
            end
            default: begin
            end
        endcase
    end

    // Registered register-file write port.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_q    <= '0;
            wdata_q <= '0;
            regwr_q <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
            regwr_q <= regwr_d;
        end
    end

    assign bus.RD    = rd_q;
    assign bus.WData = wdata_q;
    assign bus.RegWr = regwr_q;

    // Destinations of loads still buffered; x0 is never a hazard.
    always_comb begin
        pend_mask_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                pend_mask_c = pend_mask_c | (32'd1 << ent_rd[i]);
            end
        end
        pend_mask_c[0] = 1'b0;
    end

    assign bus.pend_mask = pend_mask_c;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts
// the write port one cycle ahead; a separate monitor compares every cycle.
module tb_wb_arbiter;
    import cpu_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    wb_arbiter_if #(.DEPTH(DEPTH), .DW(32), .AW(5)) bus ();

    wb_arbiter #(.DEPTH(DEPTH), .DW(32), .AW(5)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    int          checks   = 0;
    int          failures = 0;
    exp_t        expq[$];
    wb_req_t     mq[$];
    logic [4:0]  m_rd   = '0;
    logic [31:0] m_data = '0;
    exp_t        mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // One cycle: apply inputs, check combinational outputs, predict write.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                        output logic aacc, output logic lacc);
        int          n;
        logic        full;
        logic        took;
        logic [31:0] mask;
        wb_req_t     s;
        exp_t        e;
        @(posedge Clk);
        #4;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = adat;
        bus.ld_valid  = lv;
        bus.ld_rd     = lrd;
        bus.ld_data   = ldat;
        #2;
        n    = mq.size();
        full = (n == DEPTH);
        mask = '0;
        foreach (mq[i]) mask = mask | (32'd1 << mq[i].rd);
        mask[0] = 1'b0;
        chk("ld_ready",   32'(bus.ld_ready),   32'(!full));
        chk("alu_ready",  32'(bus.alu_ready),  32'(!full));
        chk("fifo_count", 32'(bus.fifo_count), 32'(n));
        chk("pend_mask",  bus.pend_mask,       mask);
        took = 1'b0;
        s    = '0;
        if (full || (!av && n > 0)) begin
            s    = mq.pop_front();
            took = 1'b1;
        end else if (av) begin
            s.rd   = ard;
            s.data = adat;
            took   = 1'b1;
        end
        if (took) begin
            m_rd   = s.rd;
            m_data = s.data;
        end
        e.we   = took && (s.rd != 5'd0);
        e.rd   = m_rd;
        e.data = m_data;
        expq.push_back(e);
        aacc = av && !full;
        lacc = lv && !full;
        if (lacc) mq.push_back({lrd, ldat});
    endtask

    task automatic idle(input int cycles);
        logic a, l;
        for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 0, a, l);
    endtask

    task automatic reset_mid();
        @(posedge Clk);
        #4;
        Reset         = 1'b1;
        bus.alu_valid = 1'b0;
        bus.ld_valid  = 1'b0;
        #1;
        chk("rst_regwr",     32'(bus.RegWr),      32'd0);
        chk("rst_fifo_cnt",  32'(bus.fifo_count), 32'd0);
        chk("rst_pend_mask", bus.pend_mask,       32'd0);
        mq.delete();
        expq.delete();
        m_rd   = '0;
        m_data = '0;
        @(posedge Clk);
        #4;
        Reset = 1'b0;
    endtask

    // Monitor: one expected write-port value per predicted cycle.
    initial begin
        forever begin
            @(posedge Clk);
            #2;
            if (expq.size() > 0) begin
                mon_e = expq.pop_front();
                chk("wb_regwr", 32'(bus.RegWr), 32'(mon_e.we));
                chk("wb_rd",    32'(bus.RD),    32'(mon_e.rd));
                chk("wb_wdata", bus.WData,      mon_e.data);
            end else begin
                chk("wb_no_write", 32'(bus.RegWr), 32'd0);
            end
        end
    end

    initial begin
        logic        aa, la, pa, pl;
        logic [4:0]  ard, lrd;
        logic [31:0] adat, ldat;
        int          k, nld;

        Reset         = 1'b1;
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_rd     = '0;
        bus.ld_data   = '0;
        #1;
        chk("init_regwr", 32'(bus.RegWr), 32'd0);
        chk("init_rd",    32'(bus.RD),    32'd0);
        chk("init_wdata", bus.WData,      32'd0);
        chk("init_count", 32'(bus.fifo_count), 32'd0);
        chk("init_pend",  bus.pend_mask,  32'd0);
        @(posedge Clk);
        #4;
        Reset = 1'b0;

        // ALU only
        step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, aa, la);
        idle(2);

        // load then ALU contention
        step(0, 0, 0, 1, 5'd7, 32'h11, aa, la);
        step(1, 5'd9, 32'h22, 0, 0, 0, aa, la);
        idle(3);

        // fill FIFO while ALU is held busy
        k   = 0;
        nld = 0;
        for (int c = 0; c < 10; c++) begin
            step(1, 5'(10 + k), 32'h1000 + 32'(k), nld < 4, 5'(nld + 1), 32'h200 + 32'(nld), aa, la);
            if (aa) k++;
            if (la) nld++;
        end
        idle(5);

        // x0 suppression
        step(1, 5'd0, 32'hFFFF, 0, 0, 0, aa, la);
        idle(1);
        step(0, 0, 0, 1, 5'd0, 32'h55, aa, la);
        idle(3);

        // reset with buffered loads
        for (int i = 0; i < 3; i++) step(1, 5'd20, 32'h300 + 32'(i), 1, 5'(i + 2), 32'h400 + 32'(i), aa, la);
        reset_mid();
        idle(4);

        // wrap-around streaming
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 5'(i + 1), 32'(i), aa, la);
        idle(3);

        // randomized traffic with held requests
        pa = 0; pl = 0; ard = 0; lrd = 0; adat = 0; ldat = 0;
        for (int c = 0; c < 400; c++) begin
            if (!pa && $urandom_range(0, 99) < 50) begin
                pa = 1; ard = 5'($urandom); adat = $urandom;
            end
            if (!pl && $urandom_range(0, 99) < 60) begin
                pl = 1; lrd = 5'($urandom); ldat = $urandom;
            end
            step(pa, ard, adat, pl, lrd, ldat, aa, la);
            if (aa) pa = 0;
            if (la) pl = 0;
            if (c == 200) begin
                reset_mid();
                pa = 0;
                pl = 0;
            end
        end
        idle(8);

        @(posedge Clk);
        @(posedge Clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
